param_barrel_shifter: RTL
=========================

// Module: param_barrel_shifter
// PURPOSE
// Sequential, counter-driven barrel shifter: a loaded word is shifted by a
// STEP-multiple amount that advances on each shift_enable and wraps at full word.
// Second generation of the counter-fed shifter: parametrised step, four shift
// modes, load/valid handshake, registered output, wrap indication.
// Sits between a data source and downstream datapath as a programmable shift stage.
// PARAMETERS
// WORD_LENGHT  16  data width in bits; must be a multiple of STEP
// STEP         2   bits shifted per count increment; 1 <= STEP <= WORD_LENGHT
// MAX_COUNT    WORD_LENGHT/STEP (derived localparam)  counter modulus
// CW           $clog2(WORD_LENGHT) (derived)  width of shift_amount
// PORTS
// clk           in   1    rising-edge clock
// reset         in   1    synchronous, active-high reset
// data_in       in   W    word to capture
// load          in   1    capture data_in, clear count
// shift_enable  in   1    advance count by one (shift += STEP)
// synch_reset   in   1    clear count only; held word retained
// mode          in   2    00 logical right, 01 logical left, 10 rotate right, 11 arithmetic right
// data_out      out  W    registered shifted word
// data_valid    out  1    data_out holds a result derived from a loaded word
// shift_amount  out  CW   shift amount applied to current data_out (count*STEP)
// wrap          out  1    one-cycle pulse, count wrapped MAX_COUNT-1 -> 0
// BEHAVIOUR
// - Internal: data_q (W), count (0..MAX_COUNT-1), a valid-pending flag.
// - reset: data_q=0, count=0, data_out=0, data_valid=0, shift_amount=0, wrap=0.
// - Priority per edge: reset > synch_reset > load > shift_enable.
// - load: data_q<=data_in, count<=0; shift_enable same cycle ignored.
// - shift_enable (no load/synch_reset): count<=count+1, MAX_COUNT-1 wraps to 0.
// - synch_reset: count<=0; data_q, data_valid unchanged; wrap not asserted.
// - Output stage, every edge (not reset): data_out <= SHIFT(data_q,count*STEP,mode),
//   shift_amount <= count*STEP; i.e. 1-cycle latency from internal state.
// - Load-to-output latency 2 edges: load edge N, data_out = data_in at edge N+1... 
//   precisely data_out valid and equal to unshifted word after edge N+1.
// - data_valid: set at edge following first load's capture edge; cleared only by reset.
// - mode is sampled combinationally with data_q/count at the output edge; mode change
//   takes effect on next data_out with no count change.
// - Logical shifts fill zeros; rotate right re-enters LSBs at MSB; arithmetic right
//   replicates data_q[W-1]. Shift amount 0 passes data_q unchanged in all modes.
// - Max shift = W-STEP; count*STEP computed in CW bits, never overflows.
// - wrap: registered, high one cycle at the output edge after the count wrap edge
//   (aligned with data_out showing shift 0 again). Not raised by load/synch_reset.
// - reset mid-operation: all state cleared on that edge; data_valid low until new load.
// - Elaboration error if WORD_LENGHT % STEP != 0 or STEP < 1.
// TESTING (defaults W=16, STEP=2)
// 1. reset, load 0xA5F0 mode 00, shift_enable x2 -> data_out 0xA5F0, 0x297C, 0x0A5F;
//    shift_amount 0,2,4; data_valid high from first result.
// 2. load 0x8000 mode 11, one shift -> 0xE000; mode 00 same count -> 0x2000.
// 3. load 0x0001 mode 10, one shift -> 0x4000; mode 01, 7 shifts -> 0x4000, amount 14.
// 4. load 0x1234, 8 consecutive shift_enable -> count wraps, wrap pulses exactly once,
//    data_out returns 0x1234, shift_amount 0.
// 5. load and shift_enable same cycle -> count 0; synch_reset mid-shift -> count 0,
//    data_q kept, no wrap pulse.
// 6. reset asserted after 3 shifts -> next cycle all outputs 0, data_valid 0;
//    shift_enable without load leaves data_out 0.

Source files
------------

// File: rtl/param_barrel_shifter_if.sv
// Bus for the counter-driven barrel shifter: load/shift controls from the
// source side, registered shifted word and status flags back from the shifter.
interface param_barrel_shifter_if #(
    parameter int unsigned WORD_LENGHT = 16,
    parameter int unsigned CW          = (WORD_LENGHT > 1) ? $clog2(WORD_LENGHT) : 1
);
    logic [WORD_LENGHT-1:0] data_in;
    logic                   load;
    logic                   shift_enable;
    logic                   synch_reset;
    logic [1:0]             mode;
    logic [WORD_LENGHT-1:0] data_out;
    logic                   data_valid;
    logic [CW-1:0]          shift_amount;
    logic                   wrap;

    modport master (
        output data_in, load, shift_enable, synch_reset, mode,
        input  data_out, data_valid, shift_amount, wrap
    );

    modport slave (
        input  data_in, load, shift_enable, synch_reset, mode,
        output data_out, data_valid, shift_amount, wrap
    );
endinterface

// File: rtl/param_barrel_shifter.sv
// Sequential barrel shifter: a captured word is shifted by count*STEP, where
// count advances on shift_enable and wraps after a full word. Four shift modes,
// registered output, one-cycle wrap indication.
module param_barrel_shifter #(
    parameter int unsigned WORD_LENGHT = 16,
    parameter int unsigned STEP        = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    param_barrel_shifter_if.slave bus
);
    localparam int unsigned W         = WORD_LENGHT;
    localparam int unsigned MAX_COUNT = WORD_LENGHT / STEP;
    localparam int unsigned CW        = (W > 1) ? $clog2(W) : 1;
    localparam int unsigned CNTW      = (MAX_COUNT > 1) ? $clog2(MAX_COUNT) : 1;

    generate
        if (STEP < 1 || (WORD_LENGHT % STEP) != 0) begin : g_bad_params
            $error("param_barrel_shifter: WORD_LENGHT must be a non-zero multiple of STEP");
        end
    endgenerate

    typedef enum logic [1:0] {
        MODE_LSR = 2'b00,
        MODE_LSL = 2'b01,
        MODE_ROR = 2'b10,
        MODE_ASR = 2'b11
    } mode_e;

    logic [W-1:0]    data_q;
    logic [CNTW-1:0] count;
    logic            valid_pending;
    logic            wrap_pending;
    logic [CW-1:0]   amount;
    logic [W-1:0]    shifted;
    logic [2*W-1:0]  rotated;
    mode_e           mode_sel;
    logic            count_at_max;

    assign count_at_max = (count == CNTW'(MAX_COUNT - 1));

    // Control state: held word, shift counter, pending valid/wrap flags
    always_ff @(posedge clk) begin
        if (reset) begin
            data_q        <= '0;
            count         <= '0;
            valid_pending <= 1'b0;
            wrap_pending  <= 1'b0;
        end else if (bus.synch_reset) begin
            count        <= '0;
            wrap_pending <= 1'b0;
        end else if (bus.load) begin
            data_q        <= bus.data_in;
            count         <= '0;
            valid_pending <= 1'b1;
            wrap_pending  <= 1'b0;
        end else if (bus.shift_enable) begin
            count        <= count_at_max ? '0 : count + 1'b1;
            wrap_pending <= count_at_max;
        end else begin
            wrap_pending <= 1'b0;
        end
    end

    // Shift network: amount never exceeds W-STEP, so it always fits in CW bits
    always_comb begin
        amount   = CW'(32'(count) * STEP);
        mode_sel = mode_e'(bus.mode);
        rotated  = {data_q, data_q} >> amount;
        shifted  = data_q;
        case (mode_sel)
            MODE_LSR: shifted = data_q >> amount;
            MODE_LSL: shifted = data_q << amount;
            MODE_ROR: shifted = rotated[W-1:0];
            MODE_ASR: shifted = $unsigned($signed(data_q) >>> amount);
            default:  shifted = data_q;
        endcase
    end

    // Output register: one cycle behind the control state
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.data_out     <= '0;
            bus.data_valid   <= 1'b0;
            bus.shift_amount <= '0;
            bus.wrap         <= 1'b0;
        end else begin
            bus.data_out     <= shifted;
            bus.data_valid   <= valid_pending;
            bus.shift_amount <= amount;
            bus.wrap         <= wrap_pending;
        end
    end
endmodule
